// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexes NUM_DIGITS snapshot BCD digits onto one
// 7-segment bus with per-digit enables.
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active-high
//   load   - snapshot strobe, samples digits when high
//   digits - packed BCD, digit 0 in bits [3:0]
//   seg    - segments {g,f,e,d,c,b,a}
//   an     - digit enables, at most one active
//   frame  - one-cycle pulse when the scan wraps back to digit 0
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic                    pre_wrap;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    blank;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign pre_wrap = (pre == LAST_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      if (load) begin
        snap <= digits;
      end
      if (pre_wrap) begin
        pre <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = '0;
    onehot    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = snap[4*i +: 4];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank digit idx when it and every more significant digit are zero;
  // digit 0 is never blanked.
  always_comb begin
    blank = (idx != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= idx) && (snap[4*i +: 4] != 4'h0)) begin
        blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = (blank ? 7'h00 : decode(cur_digit)) ^ {7{INV}};
    an_next  = ((pre == '0) ? '0 : onehot) ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= {7{INV}};
      an    <= {NUM_DIGITS{INV}};
      frame <= 1'b0;
    end else begin
      seg   <= seg_next;
      an    <= an_next;
      frame <= pre_wrap && (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits;
  logic [6:0]  seg_h, seg_l;
  logic [3:0]  an_h, an_l;
  logic        frame_h, frame_l;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passed = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h00;
`else
  localparam logic [6:0] Z = 7'h3F;
`endif

  typedef struct {
    int unsigned at;
    string       name;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;
  } exp_t;

  exp_t sb[$];

  bcd_scan_display #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .load(load), .digits(digits),
    .seg(seg_h), .an(an_h), .frame(frame_h)
  );

  bcd_scan_display #(.NUM_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .load(load), .digits(digits),
    .seg(seg_l), .an(an_l), .frame(frame_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        if ({seg_h, an_h, frame_h} === {sb[i].seg, sb[i].an, sb[i].frame})
          passed++;
        else
          $display("FAIL %s hi cyc=%0d: got seg=%h an=%b frame=%b, want seg=%h an=%b frame=%b",
                   sb[i].name, cyc, seg_h, an_h, frame_h, sb[i].seg, sb[i].an, sb[i].frame);
        checks++;
        if ({seg_l, an_l, frame_l} === {sb[i].seg ^ 7'h7F, sb[i].an ^ 4'hF, sb[i].frame})
          passed++;
        else
          $display("FAIL %s lo cyc=%0d: got seg=%h an=%b frame=%b, want seg=%h an=%b frame=%b",
                   sb[i].name, cyc, seg_l, an_l, frame_l, sb[i].seg ^ 7'h7F,
                   sb[i].an ^ 4'hF, sb[i].frame);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int unsigned at, input string name,
                           input logic [6:0] s, input logic [3:0] a, input logic f);
    exp_t e;
    e.at = at; e.name = name; e.seg = s; e.an = a; e.frame = f;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) tick();
  endtask

  task automatic load_val(input logic [15:0] v);
    load = 1'b1;
    digits = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [6:0] scan_seg [4];
    int unsigned s;
    logic [3:0] a;
    scan_seg[0] = 7'h06; scan_seg[1] = 7'h5B; scan_seg[2] = 7'h4F; scan_seg[3] = 7'h66;

    rst = 1'b1; load = 1'b0; digits = '0;

    // Reset held three cycles, then release; an=0001 on the 2nd cycle.
    wait_cyc(3);
    expect_at(3, "reset", 7'h00, 4'b0000, 1'b0);
    rst = 1'b0;
    expect_at(4, "post_rst_dead", 7'h3F, 4'b0000, 1'b0);
    expect_at(5, "post_rst_dig0", 7'h3F, 4'b0001, 1'b0);

    // Scan order with 0x4321: output at cycle c reflects scan state c-4.
    wait_cyc(4);
    load_val(16'h4321);
    for (int unsigned k = 2; k <= 32; k++) begin
      s = k;
      a = ((s % 4) == 0) ? 4'b0000 : 4'(1 << ((s / 4) % 4));
      expect_at(4 + s, "scan", scan_seg[(s / 4) % 4], a,
                ((s % 4) == 3) && (((s / 4) % 4) == 3));
    end

    // Mid-slot load during digit 1.
    wait_cyc(36);
    load_val(16'h0000);
    expect_at(38, "zero_d0",    7'h3F, 4'b0001, 1'b0);
    expect_at(40, "zero_d1_dt", Z,     4'b0000, 1'b0);
    expect_at(41, "zero_d1",    Z,     4'b0010, 1'b0);
    expect_at(42, "midslot_pre", Z,    4'b0010, 1'b0);
    expect_at(43, "midslot_9",  7'h6F, 4'b0010, 1'b0);
    expect_at(44, "d2_dt",      Z,     4'b0000, 1'b0);
    expect_at(45, "d2",         Z,     4'b0100, 1'b0);
    wait_cyc(41);
    load_val(16'h0090);

    // Non-BCD digits show a dash.
    wait_cyc(45);
    load_val(16'h00FA);
    expect_at(47, "fa_d2",      Z,     4'b0100, 1'b0);
    expect_at(48, "fa_d3_dt",   Z,     4'b0000, 1'b0);
    expect_at(49, "fa_d3",      Z,     4'b1000, 1'b0);
    expect_at(51, "fa_frame",   Z,     4'b1000, 1'b1);
    expect_at(52, "fa_d0_dt",   7'h40, 4'b0000, 1'b0);
    expect_at(53, "fa_d0",      7'h40, 4'b0001, 1'b0);
    expect_at(56, "fa_d1_dt",   7'h40, 4'b0000, 1'b0);
    expect_at(57, "fa_d1",      7'h40, 4'b0010, 1'b0);
    expect_at(61, "fa_d2b",     Z,     4'b0100, 1'b0);
    expect_at(65, "fa_d3b",     Z,     4'b1000, 1'b0);

    // Leading zeros: 0x0005 then 0x0000.
    wait_cyc(66);
    load_val(16'h0005);
    expect_at(68, "five_d0_dt", 7'h6D, 4'b0000, 1'b0);
    expect_at(69, "five_d0",    7'h6D, 4'b0001, 1'b0);
    expect_at(73, "five_d1",    Z,     4'b0010, 1'b0);
    expect_at(77, "five_d2",    Z,     4'b0100, 1'b0);
    expect_at(81, "five_d3",    Z,     4'b1000, 1'b0);
    wait_cyc(82);
    load_val(16'h0000);
    expect_at(83, "five_frame", Z,     4'b1000, 1'b1);
    expect_at(84, "nil_d0_dt",  7'h3F, 4'b0000, 1'b0);
    expect_at(85, "nil_d0",     7'h3F, 4'b0001, 1'b0);
    expect_at(89, "nil_d1",     Z,     4'b0010, 1'b0);

    // Reset mid-slot on digit 2, with a simultaneous load that must lose.
    wait_cyc(90);
    load_val(16'h1234);
    expect_at(108, "pre_rst_dt", 7'h5B, 4'b0000, 1'b0);
    expect_at(109, "pre_rst_d2", 7'h5B, 4'b0100, 1'b0);
    wait_cyc(109);
    rst = 1'b1; load = 1'b1; digits = 16'h8888;
    expect_at(110, "mid_reset", 7'h00, 4'b0000, 1'b0);
    tick();
    rst = 1'b0; load = 1'b0;
    expect_at(111, "restart_dt",  7'h3F, 4'b0000, 1'b0);
    expect_at(112, "restart_d0",  7'h3F, 4'b0001, 1'b0);
    expect_at(115, "restart_d1dt", Z,    4'b0000, 1'b0);
    expect_at(116, "restart_d1",  Z,     4'b0010, 1'b0);
    expect_at(125, "restart_d3",  Z,     4'b1000, 1'b0);
    expect_at(126, "restart_frame", Z,   4'b1000, 1'b1);

    wait_cyc(130);
    while (sb.size() > 0) begin
      checks++;
      $display("FAIL %s: expectation for cyc=%0d never compared (now cyc=%0d)",
               sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumer end of the cascaded decade-counter chain: takes NUM_DIGITS packed BCD digits plus a load strobe and time-multiplexes them onto one common-cathode/anode 7-segment bus with per-digit enables.
- Intended load source: the top-level carry pulse.
- Sits between the counter chain and the daughterboard display pins.
- Contains a refresh prescaler, a scan-index counter, a snapshot register and registered segment/enable outputs.

Parameters:
- NUM_DIGITS, 4: number of BCD digits scanned. Legal range 2..8.
- PRESCALE, 1000: clk cycles per digit slot. Minimum 2.
- ACTIVE_LOW, 1: 1 means seg and an are driven low-true; 0 means high-true.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  snapshot strobe; samples digits when high.
- digits  input  4*NUM_DIGITS  packed BCD. Digit 0 (least significant) is in bits [3:0].
- seg  output  7  segments {g,f,e,d,c,b,a}; bit 0 is a.
- an  output  NUM_DIGITS  digit enables; bit i selects digit i; at most one active.
- frame  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
Reset:
- rst is sampled on the rising edge of clk. While high, all state clears:
  - snapshot=0, prescaler=0, index=0.
  - seg and an all inactive, respecting ACTIVE_LOW.
  - frame=0.
- load is ignored while rst is high.
- On the first cycle after release, counting starts from prescaler=0, index=0.

Prescaler:
- Counts 0..PRESCALE-1, then wraps to 0.
- On the wrap cycle, index advances by 1 and wraps NUM_DIGITS-1 -> 0.

Frame:
- frame is registered.
- It is high exactly in the cycle after the prescaler wraps while index was NUM_DIGITS-1.

Snapshot:
- When load=1 at edge N, snapshot takes digits at edge N.
- The new value appears on seg no later than edge N+1. This holds mid-slot; there is no wait for a slot boundary.
- load held high continuously tracks digits with the same latency.

Outputs (registered, 1 cycle latency from prescaler/index state):
- Dead time: if the prescaler value is 0, an is all inactive (ghosting guard); otherwise only an[index] is active.
- seg is always the decode of snapshot digit[index], including during dead time.

Decode (a..g on):
- 0=abcdef
- 1=bc
- 2=abdeg
- 3=abcdg
- 4=bcfg
- 5=acdfg
- 6=acdefg
- 7=abc
- 8=abcdefg
- 9=abcdfg
- 10..15 (non-BCD): g only (dash).

Polarity:
- ACTIVE_LOW=1 inverts both seg and an after decode.
- Reset and dead-time values follow the same inversion, i.e. inactive=1.

Simultaneous events:
- load on a slot-boundary cycle: the new digit of the new index is shown.
- rst together with load: rst wins.
- rst asserted mid-slot: outputs go inactive at that edge; the scan restarts at digit 0.

Width rules:
- index is ceil(log2(NUM_DIGITS)) bits.
- prescaler is ceil(log2(PRESCALE)) bits.
- No overflow beyond the defined wraps.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - While scanning digit i (i>0), seg is all inactive if snapshot digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - an timing is unchanged.
- Undefined: all digits are always decoded, so leading zeros are shown.

Test Plan:
Bench settings: NUM_DIGITS=4, PRESCALE=4, ACTIVE_LOW=0.
1. Reset: hold rst 3 cycles -> seg=0, an=0, frame=0. After release, an=0001 appears on the 2nd post-release cycle, digit 0 decoded.
2. Scan order: load digits=0x4321 -> an sequence 0001,0010,0100,1000, each active 3 of 4 cycles with 1 dead cycle. seg sequence 0x06 (1), 0x5B (2), 0x4F (3), 0x66 (4). frame pulses once per 16 cycles.
3. Mid-slot load: during an=0010 with digits 0x0000 loaded, load digits=0x0090 -> seg becomes 0x6F (9) by the next edge, within the same slot.
4. Non-BCD: load digits=0x00FA -> digits 0 and 1 both show seg=0x40; digits 2 and 3 show 0x3F.
5. LEADING_ZERO_BLANK_EN: load 0x0005 -> digits 1-3 seg=0, digit 0 seg=0x6D. Load 0x0000 -> digit 0 seg=0x3F, others 0.
6. Reset mid-frame plus ACTIVE_LOW=1 rerun: rst during digit 2 -> seg=0x7F, an=1111 at that edge. Scan restarts at digit 0; rst with load simultaneously leaves snapshot=0.
